s_port: RTL and testbench

Target-side bus port and responder for the serial system bus driven by the initiator port (m_port).
- Deserialises the 16-bit address and 8-bit write data from the serial bus and presents them to a local slave as one-cycle parallel strobes.
- Serialises read data back onto the bus and generates the s_ack and s_split responses.
- Sits between the bus mux/decoder and one slave memory or peripheral.

---
 rtl/bus_pkg.sv | 18 +
 rtl/s_port_rx_shift.sv | 43 ++++
 rtl/s_port.sv | 180 ++++++++++++++++++
 tb/tb_s_port.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared widths, bus_mode encodings and the s_port state type for the serial system bus.
package bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_DATA = 1'b1;

    typedef enum logic [2:0] {
        ADDR, WDATA, WR_ACK, RD_WAIT, RD_HOLD, RD_SEND, RD_ACK
    } s_port_state_t;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] match,
                                      input logic [ADDR_W-1:0] mask);
        return (addr & mask) == (match & mask);
    endfunction
endpackage

// File: rtl/s_port_rx_shift.sv
// LSB-first serial-to-parallel shifter; done pulses combinationally with the last bit
// and word presents the completed value in that same cycle.
module s_port_rx_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic [W-1:0] word,
    output logic         done
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        word  = {in_bit, sr_q[W-1:1]};
        done  = in_valid && !clr && (cnt_q == LAST);
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            sr_d  = word;
            cnt_d = done ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/s_port.sv
// Target-side serial bus port: captures address/write data, strobes the local slave,
// serialises read data and issues s_ack/s_split. Address decode: S_PORT_ADDR_DECODE_EN.
module s_port
    import bus_pkg::*;
#(
    parameter int               SPLIT_THRESHOLD = 2,
    parameter logic [ADDR_W-1:0] ADDR_MATCH     = 16'h0000,
    parameter logic [ADDR_W-1:0] ADDR_MASK      = 16'hF000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_data_out,
    input  logic              bus_data_out_valid,
    input  logic              bus_mode,
    input  logic              bus_m_rw,
    output logic              bus_data_in,
    output logic              bus_data_in_valid,
    output logic              s_ack,
    output logic              s_split,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wr_en,
    output logic              s_rd_req,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_rd_valid
);
`ifdef S_PORT_ADDR_DECODE_EN
    localparam logic DECODE_EN = 1'b1;
`else
    localparam logic DECODE_EN = 1'b0;
`endif
    localparam int WCW = $clog2(SPLIT_THRESHOLD + 1) + 1;
    localparam logic [WCW-1:0] THR = WCW'(SPLIT_THRESHOLD);

    s_port_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              wr_en_q, wr_en_d, rd_req_q, rd_req_d, ack_q, ack_d, split_q, split_d;
    logic              din_q, din_d, din_vld_q, din_vld_d, split_done_q, split_done_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [3:0]        send_q, send_d;

    logic              addr_in, data_in, data_clr, addr_done, data_done, hit;
    logic [ADDR_W-1:0] addr_word;
    logic [DATA_W-1:0] data_word;

    assign addr_in  = bus_data_out_valid && bus_mode == MODE_ADDR &&
                      (state_q == ADDR || state_q == WDATA);
    assign data_in  = bus_data_out_valid && bus_mode == MODE_DATA && state_q == WDATA;
    // An address-phase bit inside WDATA abandons the write; the address shifter keeps it as bit 0.
    assign data_clr = rst || (state_q == WDATA && bus_data_out_valid && bus_mode == MODE_ADDR);
    assign hit      = !DECODE_EN || addr_hit(addr_word, ADDR_MATCH, ADDR_MASK);

    s_port_rx_shift #(.W(ADDR_W)) u_addr_sh (
        .clk(clk), .rst(rst), .clr(rst), .in_valid(addr_in), .in_bit(bus_data_out),
        .word(addr_word), .done(addr_done)
    );

    s_port_rx_shift #(.W(DATA_W)) u_data_sh (
        .clk(clk), .rst(rst), .clr(data_clr), .in_valid(data_in), .in_bit(bus_data_out),
        .word(data_word), .done(data_done)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        wait_d       = wait_q;
        split_done_d = split_done_q;
        send_d       = send_q;
        wr_en_d      = 1'b0;
        rd_req_d     = 1'b0;
        ack_d        = 1'b0;
        split_d      = 1'b0;
        din_d        = 1'b0;
        din_vld_d    = 1'b0;
        case (state_q)
            ADDR: begin
                if (addr_done && hit) begin
                    addr_d = addr_word;
                    if (bus_m_rw) begin
                        state_d = WDATA;
                    end else begin
                        rd_req_d     = 1'b1;
                        wait_d       = '0;
                        split_done_d = 1'b0;
                        state_d      = RD_WAIT;
                    end
                end
            end
            WDATA: begin
                if (data_clr) begin
                    state_d = ADDR;
                end else if (data_done) begin
                    wdata_d = data_word;
                    wr_en_d = 1'b1;
                    state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                ack_d   = 1'b1;
                state_d = ADDR;
            end
            RD_WAIT: begin
                if (s_rd_valid) begin
                    rdata_d = s_rd_data;
                    state_d = RD_HOLD;
                end else begin
                    if (SPLIT_THRESHOLD != 0 && wait_q == THR && !split_done_q) begin
                        split_d      = 1'b1;
                        split_done_d = 1'b1;
                    end
                    if (wait_q < THR) wait_d = wait_q + WCW'(1);
                end
            end
            RD_HOLD: begin
                if (bus_mode == MODE_DATA && !bus_data_out_valid) begin
                    din_d     = rdata_q[0];
                    din_vld_d = 1'b1;
                    send_d    = 4'd1;
                    state_d   = RD_SEND;
                end
            end
            RD_SEND: begin
                if (send_q == 4'd8) begin
                    ack_d   = 1'b1;
                    state_d = RD_ACK;
                end else begin
                    din_d     = rdata_q[send_q[2:0]];
                    din_vld_d = 1'b1;
                    send_d    = send_q + 4'd1;
                end
            end
            RD_ACK:  state_d = ADDR;
            default: state_d = ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ADDR;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            wait_q       <= '0;
            split_done_q <= 1'b0;
            send_q       <= '0;
            wr_en_q      <= 1'b0;
            rd_req_q     <= 1'b0;
            ack_q        <= 1'b0;
            split_q      <= 1'b0;
            din_q        <= 1'b0;
            din_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            wait_q       <= wait_d;
            split_done_q <= split_done_d;
            send_q       <= send_d;
            wr_en_q      <= wr_en_d;
            rd_req_q     <= rd_req_d;
            ack_q        <= ack_d;
            split_q      <= split_d;
            din_q        <= din_d;
            din_vld_q    <= din_vld_d;
        end
    end

    assign s_addr            = addr_q;
    assign s_wdata           = wdata_q;
    assign s_wr_en           = wr_en_q;
    assign s_rd_req          = rd_req_q;
    assign s_ack             = ack_q;
    assign s_split           = split_q;
    assign bus_data_in       = din_q;
    assign bus_data_in_valid = din_vld_q;
endmodule

// File: tb/tb_s_port.sv
// Scoreboard bench for s_port: tasks push expected events, a negedge monitor pops and compares.
module tb_s_port;
    localparam int THR = 2;
`ifdef S_PORT_ADDR_DECODE_EN
    localparam logic [15:0] A_BASE = 16'h1000;
`else
    localparam logic [15:0] A_BASE = 16'h0000;
`endif
    localparam logic [2:0] K_WR = 3'd1, K_RQ = 3'd2, K_SP = 3'd3, K_RB = 3'd4, K_ACK = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] a;
        logic [7:0]  d;
    } ev_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        bus_data_out = 0, bus_data_out_valid = 0, bus_mode = 0, bus_m_rw = 0;
    logic        bus_data_in, bus_data_in_valid, s_ack, s_split, s_wr_en, s_rd_req;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;
    logic [7:0]  s_rd_data = 8'h00;
    logic        s_rd_valid = 1'b0;

    int checks = 0, failures = 0;
    int cyc = 0, wr_cyc = 0, ack_cyc = 0, bit_cyc = 0, wr_cnt = 0, ack_cnt = 0;
    ev_t exp_q[$];
    ev_t obs[$];
    ev_t e;
    logic [7:0] acc;
    int acc_n = 0;

    s_port #(.SPLIT_THRESHOLD(THR), .ADDR_MATCH(A_BASE), .ADDR_MASK(16'hF000)) dut (
        .clk(clk), .rst(rst), .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
        .bus_mode(bus_mode), .bus_m_rw(bus_m_rw), .bus_data_in(bus_data_in),
        .bus_data_in_valid(bus_data_in_valid), .s_ack(s_ack), .s_split(s_split), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wr_en(s_wr_en), .s_rd_req(s_rd_req), .s_rd_data(s_rd_data),
        .s_rd_valid(s_rd_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
        ev_t r;
        r.kind = k; r.a = a; r.d = d;
        return r;
    endfunction

    // Monitor: collect this cycle's output events and compare in order against the scoreboard.
    always @(negedge clk) begin
        obs.delete();
        if (rst) begin
            acc_n = 0;
        end else begin
            checks++;
            if (s_ack && s_split) begin
                failures++; $display("FAIL ack_split_excl got=1 exp=0");
            end
            checks++;
            if (s_wr_en && s_rd_req) begin
                failures++; $display("FAIL wr_rd_excl got=1 exp=0");
            end
            checks++;
            if (!bus_data_in_valid && bus_data_in !== 1'b0) begin
                failures++; $display("FAIL idle_data_in got=%b exp=0", bus_data_in);
            end
            if (s_wr_en) begin
                obs.push_back(mk(K_WR, s_addr, s_wdata)); wr_cyc = cyc; wr_cnt++;
            end
            if (s_rd_req) obs.push_back(mk(K_RQ, s_addr, 8'h00));
            if (s_split)  obs.push_back(mk(K_SP, 16'h0, 8'h00));
            if (bus_data_in_valid) begin
                acc[acc_n] = bus_data_in;
                acc_n++;
                if (acc_n == 8) begin
                    obs.push_back(mk(K_RB, 16'h0, acc)); acc_n = 0; bit_cyc = cyc;
                end
            end else if (acc_n != 0) begin
                checks++; failures++;
                $display("FAIL serial_gap bits=%0d exp=8", acc_n);
                acc_n = 0;
            end
            if (s_ack) begin
                obs.push_back(mk(K_ACK, 16'h0, 8'h00)); ack_cyc = cyc; ack_cnt++;
            end
            foreach (obs[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL unexpected_event got=%h exp=none", obs[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (obs[i] !== e) begin
                        failures++; $display("FAIL event got=%h exp=%h", obs[i], e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic rw);
        for (int i = 0; i < 16; i++) begin
            bus_data_out_valid = 1; bus_mode = 0; bus_data_out = a[i]; bus_m_rw = rw;
            tick();
        end
        bus_data_out_valid = 0; bus_mode = 1; bus_data_out = 0;
    endtask

    task automatic send_data(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus_data_out_valid = 1; bus_mode = 1; bus_data_out = d[i];
            tick();
        end
        bus_data_out_valid = 0; bus_data_out = 0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL %s_drain pending=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    // Slave side: wait for s_rd_req, then answer `delay` cycles later.
    task automatic finish_read(input logic [7:0] d, input int delay, input string name);
        int g = 0;
        while (!s_rd_req && g < 40) begin tick(); g++; end
        repeat (delay) tick();
        s_rd_valid = 1; s_rd_data = d;
        tick();
        s_rd_valid = 0; s_rd_data = ~d;
        drain(60, name);
        checks++;
        if (ack_cyc !== bit_cyc + 1) begin
            failures++; $display("FAIL %s_ack_timing got=%0d exp=%0d", name, ack_cyc, bit_cyc + 1);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit ok, input string name);
        if (ok) begin
            exp_q.push_back(mk(K_WR, a, d));
            exp_q.push_back(mk(K_ACK, 16'h0, 8'h00));
        end
        send_addr(a, 1);
        send_data(d, 8);
        drain(20, name);
        if (ok) begin
            checks++;
            if (s_addr !== a) begin
                failures++; $display("FAIL %s_addr got=%h exp=%h", name, s_addr, a);
            end
            checks++;
            if (s_wdata !== d) begin
                failures++; $display("FAIL %s_wdata got=%h exp=%h", name, s_wdata, d);
            end
            checks++;
            if (ack_cyc !== wr_cyc + 1) begin
                failures++; $display("FAIL %s_ack_timing got=%0d exp=%0d", name, ack_cyc, wr_cyc + 1);
            end
        end
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] d, input int delay, input string name);
        exp_q.push_back(mk(K_RQ, a, 8'h00));
        if (THR != 0 && delay > THR) exp_q.push_back(mk(K_SP, 16'h0, 8'h00));
        exp_q.push_back(mk(K_RB, 16'h0, d));
        exp_q.push_back(mk(K_ACK, 16'h0, 8'h00));
        send_addr(a, 0);
        finish_read(d, delay, name);
    endtask

    task automatic test_reset();
        rst = 1;
        send_addr(16'hFFFF, 1);
        checks++;
        if ({bus_data_in, bus_data_in_valid, s_ack, s_split, s_wr_en, s_rd_req} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000",
                                 {bus_data_in, bus_data_in_valid, s_ack, s_split, s_wr_en, s_rd_req});
        end
        checks++;
        if ({s_addr, s_wdata} !== 24'h0) begin
            failures++; $display("FAIL reset_regs got=%h exp=000000", {s_addr, s_wdata});
        end
        rst = 0;
        tick();
    endtask

    task automatic test_write();
        do_write(A_BASE | 16'h0012, 8'h3C, 1, "write");
    endtask

    task automatic test_read();
        do_read(A_BASE | 16'h0034, 8'h96, 1, "read_fast");
        do_read(A_BASE | 16'h0056, 8'hA5, THR, "read_thr_edge");
        do_read(A_BASE | 16'h0034, 8'h96, 4, "read_split");
    endtask

    task automatic test_abort();
        int w0 = wr_cnt;
        exp_q.push_back(mk(K_RQ, A_BASE | 16'h00AB, 8'h00));
        exp_q.push_back(mk(K_RB, 16'h0, 8'h5A));
        exp_q.push_back(mk(K_ACK, 16'h0, 8'h00));
        send_addr(A_BASE | 16'h0005, 1);
        send_data(8'h3C, 3);
        send_addr(A_BASE | 16'h00AB, 0);
        checks++;
        if (s_addr !== (A_BASE | 16'h00AB)) begin
            failures++; $display("FAIL abort_addr got=%h exp=%h", s_addr, A_BASE | 16'h00AB);
        end
        finish_read(8'h5A, 1, "abort");
        checks++;
        if (wr_cnt !== w0) begin
            failures++; $display("FAIL abort_no_wr got=%0d exp=%0d", wr_cnt, w0);
        end
    endtask

    task automatic test_reset_mid_send();
        int n = 0, g = 0, a0;
        exp_q.push_back(mk(K_RQ, A_BASE | 16'h0034, 8'h00));
        send_addr(A_BASE | 16'h0034, 0);
        while (!s_rd_req && g < 40) begin tick(); g++; end
        tick();
        s_rd_valid = 1; s_rd_data = 8'h96;
        tick();
        s_rd_valid = 0;
        g = 0;
        while (n < 5 && g < 60) begin
            tick(); g++;
            if (bus_data_in_valid) n++;
        end
        checks++;
        if (n != 5) begin
            failures++; $display("FAIL rst_send_reach got=%0d exp=5", n);
        end
        a0 = ack_cnt;
        rst = 1;
        tick();
        checks++;
        if ({bus_data_in, bus_data_in_valid, s_ack, s_split, s_wr_en, s_rd_req, s_addr, s_wdata} !== 30'h0) begin
            failures++; $display("FAIL rst_send_outputs got=%h exp=0",
                {bus_data_in, bus_data_in_valid, s_ack, s_split, s_wr_en, s_rd_req, s_addr, s_wdata});
        end
        tick();
        rst = 0;
        drain(10, "rst_send");
        checks++;
        if (ack_cnt !== a0) begin
            failures++; $display("FAIL rst_send_no_ack got=%0d exp=%0d", ack_cnt, a0);
        end
        do_write(A_BASE | 16'h0001, 8'h55, 1, "post_rst_write");
    endtask

    task automatic test_decode();
        int w0;
        logic [7:0] wd0;
`ifdef S_PORT_ADDR_DECODE_EN
        w0 = wr_cnt; wd0 = s_wdata;
        do_write(16'h2003, 8'h77, 0, "decode_miss");
        checks++;
        if (wr_cnt !== w0 || s_wdata !== wd0) begin
            failures++; $display("FAIL decode_miss_strobe got=%0d/%h exp=%0d/%h", wr_cnt, s_wdata, w0, wd0);
        end
        do_write(16'h1003, 8'h77, 1, "decode_hit");
`else
        w0 = wr_cnt; wd0 = 8'h77;
        do_write(16'h2003, wd0, 1, "no_decode");
        checks++;
        if (wr_cnt !== w0 + 1) begin
            failures++; $display("FAIL no_decode_count got=%0d exp=%0d", wr_cnt, w0 + 1);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_write(A_BASE | 16'h0ABC, 8'hC3, 1, "b2b_write");
        do_read(A_BASE | 16'h0ABC, 8'h01, 0, "b2b_read");
        do_write(A_BASE | 16'h0F0F, 8'h80, 1, "b2b_write2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_mid_send();
        test_decode();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
